interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Upstream sequencing stage for the CPU instruction controller: synchronises external NMI/IRQ lines, edge-detects NMI, tracks the power-on RESET sequence, and produces the registered `interrupt_flag` that forces a BRK opcode (0x00) into the instruction register at the next T1 load. It also tells the BRK microsequence which vector to fetch, whether to push B=1, and whether stack writes are suppressed (RESET).

## Interface
- No parameters.
- `sys_clock  in  1` — main system clock; all state changes on its rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `clk_phase_1  in  1` — single-cycle phase-1 enable strobe, shared with the instruction controller.
- `clk_phase_2  in  1` — single-cycle phase-2 enable strobe.
- `nmi_n  in  1` — external NMI, active low, asynchronous.
- `irq_n  in  1` — external IRQ, active low, level, asynchronous.
- `i_flag  in  1` — processor status I bit; 1 masks IRQ.
- `next_cycle  in  3` — next instruction cycle from the instruction controller.
- `interrupt_flag  out  1` — registered; 1 means the next T1 load becomes BRK.
- `interrupt_type  out  2` — latched source of the sequence in service: 0 = SW_BRK, 1 = IRQ, 2 = NMI, 3 = RESET.
- `vector_lo  out  8` — low byte of the vector address: 0xFC for RESET, 0xFA for NMI, 0xFE for IRQ and SW_BRK. High byte is always 0xFF.
- `b_flag_push  out  1` — 1 only for SW_BRK.
- `suppress_write  out  1` — 1 only while a RESET sequence is in service.
- `in_service  out  1` — 1 while the state is SERVICE.

## Operation
- **Synchronisers.** Each of `nmi_n` and `irq_n` passes through a 2-flop synchroniser clocked every `sys_clock`. Both flops reset to 1.
- **NMI edge detect.** On each `clk_phase_2` strobe, a 1→0 transition of synchronised `nmi_n` sets `nmi_pending`. A held-low level never sets it again; the line must return high before a new edge is recognised.
- **IRQ request.** `irq_req = !irq_sync & !i_flag`. IRQ is not latched; if the line is released before the poll, the request is lost.
- **Poll.** On each `clk_phase_2` strobe:
  - In IDLE: `interrupt_flag <= nmi_pending | irq_req`.
  - In SERVICE: `interrupt_flag <= 0`.
- **State machine.** Two states: IDLE and SERVICE.
  - IDLE → SERVICE on a `clk_phase_1` strobe with `next_cycle == 1` and `interrupt_flag == 1`.
    - Latch `interrupt_type` by priority: NMI if `nmi_pending`, else IRQ.
    - Clear `nmi_pending` only if NMI was taken.
    - Clear `interrupt_flag`.
  - IDLE, `clk_phase_1` strobe with `next_cycle == 1` and `interrupt_flag == 0`: set `interrupt_type <= SW_BRK`. The field is meaningful only if the fetched opcode is BRK.
  - SERVICE → IDLE on the next `clk_phase_1` strobe with `next_cycle == 1`, i.e. the fetch after the vector load.
- **Reset.** `rst` forces SERVICE with `interrupt_type = RESET`, because the instruction controller also resets into BRK at cycle 0. While `rst` is high, incoming NMI/IRQ are ignored.
- **Decoded outputs** (combinational from the registered state/type):
  - `vector_lo` per `interrupt_type`.
  - `b_flag_push = (type == SW_BRK)`.
  - `suppress_write = in_service & (type == RESET)`.

## Timing
- **Reset values:**
  - state = SERVICE, `in_service = 1`, `interrupt_type = 3`
  - `vector_lo = 0xFC`, `suppress_write = 1`, `b_flag_push = 0`
  - `interrupt_flag = 0`, `nmi_pending = 0`, all synchroniser flops = 1.
- **Latency:**
  - Pin change to synchronised value: 2 `sys_clock` cycles.
  - Synchronised value to `interrupt_flag`: the next `clk_phase_2` strobe.
  - `interrupt_flag` to state entry: the `clk_phase_1` strobe where `next_cycle == 1`.
- `interrupt_flag` is stable from a phase-2 strobe through the following phase-1 strobe.
- **Simultaneous strobes.** The two strobes are mutually exclusive by design. If both are high, only the `clk_phase_1` actions are performed.
- **NMI edge during SERVICE** (any type): `nmi_pending` stays set. It is taken at the first poll after returning to IDLE, one instruction boundary later.
- **IRQ and NMI both pending at a poll:** NMI wins; IRQ is re-evaluated at the next poll.
- **`i_flag` rising between poll and entry:** the already-registered flag is honoured and the interrupt is still taken.
- **`rst` mid-SERVICE (e.g. during an NMI):** type becomes RESET and `nmi_pending` is cleared.

## Structure
- Shared CPU package holds:
  - type encodings `INT_SW_BRK`, `INT_IRQ`, `INT_NMI`, `INT_RESET`
  - vector constants `VEC_NMI_LO = 0xFA`, `VEC_RES_LO = 0xFC`, `VEC_IRQ_LO = 0xFE`
  - `OPC_BRK = 0x00`.
- One sub-module, `signal_synchronizer` (2-flop, reset value 1), instantiated twice.

## Test plan
- **Reset release.** Assert `rst` for 3 cycles, then release; step phases with `next_cycle = 1` once.
  - After release: `in_service = 1`, `vector_lo = 0xFC`, `suppress_write = 1`.
  - After that phase-1 strobe: IDLE, `suppress_write = 0`.
- **NMI edge.** Drop `nmi_n` in IDLE.
  - `interrupt_flag = 1` at the next phase-2 strobe (after the 2-cycle sync).
  - At the phase-1 strobe with `next_cycle = 1`: `interrupt_type = 2`, `vector_lo = 0xFA`, `nmi_pending = 0`.
  - Holding `nmi_n` low afterwards produces no second entry.
- **IRQ masking.** Hold `irq_n = 0`:
  - with `i_flag = 1`: `interrupt_flag` stays 0.
  - after clearing `i_flag`: `interrupt_flag = 1` at the next phase-2 strobe, `vector_lo = 0xFE`, `b_flag_push = 0`.
- **Priority.** NMI edge and IRQ low at the same poll → NMI taken first. Once back in IDLE, IRQ is taken at the next poll.
- **NMI during IRQ service.** Edge arrives while SERVICE(IRQ): `interrupt_flag` stays 0 until exit, then NMI is taken at the following boundary.
- **Software BRK.** No requests pending, phase-1 strobe with `next_cycle = 1`: `interrupt_type = 0`, `b_flag_push = 1`, `vector_lo = 0xFE`, state stays IDLE.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared CPU definitions for interrupt sequencing: source encodings, vector
// low bytes and the opcode forced into the instruction register.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    INT_SW_BRK = 2'd0,
    INT_IRQ    = 2'd1,
    INT_NMI    = 2'd2,
    INT_RESET  = 2'd3
  } int_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } int_state_e;

  localparam logic [7:0] VEC_NMI_LO = 8'hFA;
  localparam logic [7:0] VEC_RES_LO = 8'hFC;
  localparam logic [7:0] VEC_IRQ_LO = 8'hFE;
  localparam logic [7:0] VEC_HI     = 8'hFF;
  localparam logic [7:0] OPC_BRK    = 8'h00;

  localparam logic [2:0] CYCLE_T1 = 3'd1;

  // Software BRK shares the IRQ vector; only the pushed B bit tells them apart.
  function automatic logic [7:0] vector_lo_of(input int_type_e t);
    case (t)
      INT_NMI:   vector_lo_of = VEC_NMI_LO;
      INT_RESET: vector_lo_of = VEC_RES_LO;
      default:   vector_lo_of = VEC_IRQ_LO;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_controller_sync.sv
// Two-flop synchroniser for asynchronous active-low request lines; both
// stages reset high so an idle line never looks asserted out of reset.
module signal_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt sequencing ahead of the instruction controller: synchronises
// NMI/IRQ, edge-detects NMI, tracks RESET and raises the BRK-forcing flag.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic       sys_clock,
  input  logic       rst,
  input  logic       clk_phase_1,
  input  logic       clk_phase_2,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic [2:0] next_cycle,
  output logic       interrupt_flag,
  output logic [1:0] interrupt_type,
  output logic [7:0] vector_lo,
  output logic       b_flag_push,
  output logic       suppress_write,
  output logic       in_service
);

  logic nmi_sync;
  logic irq_sync;

  signal_synchronizer u_nmi_sync (
    .clk      (sys_clock),
    .rst      (rst),
    .async_in (nmi_n),
    .sync_out (nmi_sync)
  );

  signal_synchronizer u_irq_sync (
    .clk      (sys_clock),
    .rst      (rst),
    .async_in (irq_n),
    .sync_out (irq_sync)
  );

  int_state_e state_q, state_d;
  int_type_e  type_q, type_d;
  logic       flag_q, flag_d;
  logic       nmi_pending_q, nmi_pending_d;
  logic       nmi_prev_q, nmi_prev_d;

  logic irq_req;
  logic p2_act;
  logic boundary;

  assign irq_req  = !irq_sync & !i_flag;
  // Phase 1 wins if both strobes ever coincide.
  assign p2_act   = clk_phase_2 & !clk_phase_1;
  assign boundary = clk_phase_1 & (next_cycle == CYCLE_T1);

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    flag_d        = flag_q;
    nmi_pending_d = nmi_pending_q;
    nmi_prev_d    = nmi_prev_q;

    if (p2_act) begin
      nmi_prev_d = nmi_sync;
      if (nmi_prev_q & !nmi_sync) begin
        nmi_pending_d = 1'b1;
      end
      // A fresh NMI edge is visible to the poll on the same strobe.
      flag_d = (state_q == ST_IDLE) ? (nmi_pending_d | irq_req) : 1'b0;
    end

    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (flag_q) begin
            state_d = ST_SERVICE;
            flag_d  = 1'b0;
            if (nmi_pending_q) begin
              type_d        = INT_NMI;
              nmi_pending_d = 1'b0;
            end else begin
              type_d = INT_IRQ;
            end
          end else begin
            type_d = INT_SW_BRK;
          end
        end
        ST_SERVICE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      state_q       <= ST_SERVICE;
      type_q        <= INT_RESET;
      flag_q        <= 1'b0;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      flag_q        <= flag_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_prev_d;
    end
  end

  assign interrupt_flag = flag_q;
  assign interrupt_type = type_q;
  assign in_service     = (state_q == ST_SERVICE);
  assign vector_lo      = vector_lo_of(type_q);
  assign b_flag_push    = (type_q == INT_SW_BRK);
  assign suppress_write = in_service & (type_q == INT_RESET);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: reset, NMI edge, IRQ masking,
// priority, NMI during service, software BRK and reset mid-service.
module tb_interrupt_controller;

  logic       sys_clock = 1'b0;
  logic       rst = 1'b1;
  logic       clk_phase_1 = 1'b0;
  logic       clk_phase_2 = 1'b0;
  logic       nmi_n = 1'b1;
  logic       irq_n = 1'b1;
  logic       i_flag = 1'b1;
  logic [2:0] next_cycle = 3'd1;
  logic       interrupt_flag;
  logic [1:0] interrupt_type;
  logic [7:0] vector_lo;
  logic       b_flag_push;
  logic       suppress_write;
  logic       in_service;

  int total = 0;
  int bad = 0;

  interrupt_controller dut (
    .sys_clock      (sys_clock),
    .rst            (rst),
    .clk_phase_1    (clk_phase_1),
    .clk_phase_2    (clk_phase_2),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .i_flag         (i_flag),
    .next_cycle     (next_cycle),
    .interrupt_flag (interrupt_flag),
    .interrupt_type (interrupt_type),
    .vector_lo      (vector_lo),
    .b_flag_push    (b_flag_push),
    .suppress_write (suppress_write),
    .in_service     (in_service)
  );

  // clock
  always #5 sys_clock = ~sys_clock;

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clock);
  endtask

  task automatic step_p1(input logic [2:0] nc);
    next_cycle  = nc;
    clk_phase_1 = 1'b1;
    @(negedge sys_clock);
    clk_phase_1 = 1'b0;
    @(negedge sys_clock);
  endtask

  task automatic step_p2();
    clk_phase_2 = 1'b1;
    @(negedge sys_clock);
    clk_phase_2 = 1'b0;
    @(negedge sys_clock);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic svc, input logic [1:0] t,
                            input logic [7:0] vec, input logic bpush, input logic sup);
    check({tag, ".in_service"}, {7'd0, in_service}, {7'd0, svc});
    check({tag, ".type"}, {6'd0, interrupt_type}, {6'd0, t});
    check({tag, ".vector_lo"}, vector_lo, vec);
    check({tag, ".b_flag_push"}, {7'd0, b_flag_push}, {7'd0, bpush});
    check({tag, ".suppress_write"}, {7'd0, suppress_write}, {7'd0, sup});
  endtask

  initial begin
    // reset release
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(1);
    check_outs("reset", 1'b1, 2'd3, 8'hFC, 1'b0, 1'b1);
    check("reset.flag", {7'd0, interrupt_flag}, 8'd0);
    check("reset.nmi_pending", {7'd0, dut.nmi_pending_q}, 8'd0);
    step_p2();
    step_p1(3'd1);
    check_outs("reset_exit", 1'b0, 2'd3, 8'hFC, 1'b0, 1'b0);

    // NMI edge in IDLE
    nmi_n = 1'b0;
    idle_cycles(3);
    step_p2();
    check("nmi.flag", {7'd0, interrupt_flag}, 8'd1);
    check("nmi.pending", {7'd0, dut.nmi_pending_q}, 8'd1);
    step_p1(3'd4);
    check("nmi.no_entry_off_t1", {7'd0, in_service}, 8'd0);
    check("nmi.flag_held", {7'd0, interrupt_flag}, 8'd1);
    step_p1(3'd1);
    check_outs("nmi.entry", 1'b1, 2'd2, 8'hFA, 1'b0, 1'b0);
    check("nmi.pending_clr", {7'd0, dut.nmi_pending_q}, 8'd0);
    check("nmi.flag_clr", {7'd0, interrupt_flag}, 8'd0);
    step_p2();
    step_p1(3'd1);
    check("nmi.exit", {7'd0, in_service}, 8'd0);
    // held low: no second entry; the T1 fetch is then a plain software BRK
    step_p2();
    check("nmi.held_flag", {7'd0, interrupt_flag}, 8'd0);
    step_p1(3'd1);
    check_outs("sw_brk", 1'b0, 2'd0, 8'hFE, 1'b1, 1'b0);
    nmi_n = 1'b1;
    idle_cycles(3);
    step_p2();

    // IRQ masking
    irq_n = 1'b0;
    i_flag = 1'b1;
    idle_cycles(3);
    step_p2();
    check("irq.masked_flag", {7'd0, interrupt_flag}, 8'd0);
    i_flag = 1'b0;
    step_p2();
    check("irq.flag", {7'd0, interrupt_flag}, 8'd1);
    i_flag = 1'b1;
    step_p1(3'd1);
    check_outs("irq.entry_after_mask", 1'b1, 2'd1, 8'hFE, 1'b0, 1'b0);
    step_p2();
    step_p1(3'd1);
    check("irq.exit", {7'd0, in_service}, 8'd0);

    // priority: NMI edge and IRQ at the same poll
    i_flag = 1'b0;
    nmi_n = 1'b0;
    idle_cycles(3);
    step_p2();
    check("prio.flag", {7'd0, interrupt_flag}, 8'd1);
    step_p1(3'd1);
    check_outs("prio.nmi_first", 1'b1, 2'd2, 8'hFA, 1'b0, 1'b0);
    step_p2();
    check("prio.svc_flag", {7'd0, interrupt_flag}, 8'd0);
    step_p1(3'd1);
    step_p2();
    check("prio.irq_flag", {7'd0, interrupt_flag}, 8'd1);
    step_p1(3'd1);
    check_outs("prio.irq_next", 1'b1, 2'd1, 8'hFE, 1'b0, 1'b0);

    // NMI edge during IRQ service
    nmi_n = 1'b1;
    idle_cycles(3);
    step_p2();
    nmi_n = 1'b0;
    idle_cycles(3);
    step_p2();
    check("nmi_in_svc.pending", {7'd0, dut.nmi_pending_q}, 8'd1);
    check("nmi_in_svc.flag", {7'd0, interrupt_flag}, 8'd0);
    irq_n = 1'b1;
    i_flag = 1'b1;
    idle_cycles(3);
    step_p1(3'd1);
    check_outs("nmi_in_svc.exit", 1'b0, 2'd1, 8'hFE, 1'b0, 1'b0);
    step_p2();
    check("nmi_in_svc.flag_after", {7'd0, interrupt_flag}, 8'd1);
    step_p1(3'd1);
    check_outs("nmi_in_svc.taken", 1'b1, 2'd2, 8'hFA, 1'b0, 1'b0);

    // reset while an NMI is pending mid-service
    nmi_n = 1'b1;
    idle_cycles(3);
    step_p2();
    nmi_n = 1'b0;
    idle_cycles(3);
    step_p2();
    check("rst_mid.pending_before", {7'd0, dut.nmi_pending_q}, 8'd1);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(1);
    check_outs("rst_mid", 1'b1, 2'd3, 8'hFC, 1'b0, 1'b1);
    check("rst_mid.pending", {7'd0, dut.nmi_pending_q}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
